// File: rtl/apex_seq_pkg.sv
// Shared encodings for the proof-of-execution sequencer: FSM states, fault codes,
// config-window word offsets and CTRL bit positions.
package apex_seq_pkg;

    typedef enum logic [2:0] {
        StIdle  = 3'd0,
        StArmed = 3'd1,
        StRun   = 3'd2,
        StDone  = 3'd3,
        StFault = 3'd4
    } state_e;

    localparam logic [2:0] FAULT_NONE         = 3'd0;
    localparam logic [2:0] FAULT_CFG_BAD      = 3'd1;
    localparam logic [2:0] FAULT_ILLEGAL_EXIT = 3'd2;
    localparam logic [2:0] FAULT_IRQ          = 3'd3;
    localparam logic [2:0] FAULT_CFG_WRITE    = 3'd4;
    localparam logic [2:0] FAULT_TIMEOUT      = 3'd5;

    localparam logic [3:0] OFS_ERMIN = 4'd0;
    localparam logic [3:0] OFS_ERMAX = 4'd2;
    localparam logic [3:0] OFS_ORMIN = 4'd4;
    localparam logic [3:0] OFS_ORMAX = 4'd6;
    localparam logic [3:0] OFS_CTRL  = 4'd8;

    localparam int unsigned CTRL_ARM = 0;
    localparam int unsigned CTRL_CLR = 1;

    // Closed intervals [a_lo,a_hi] and [b_lo,b_hi] share at least one address.
    function automatic logic ranges_overlap(input logic [15:0] a_lo, input logic [15:0] a_hi,
                                            input logic [15:0] b_lo, input logic [15:0] b_hi);
        return (a_lo <= b_hi) && (b_lo <= a_hi);
    endfunction

endpackage

// File: rtl/apex_exec_sequencer_cfg_regfile.sv
// Config window decoder for the sequencer: holds ER/OR bound registers and turns
// bus writes into arm/clear/config-write pulses. Bound writes land only when the
// FSM grants cfg_we_i; otherwise they are dropped here.
module apex_cfg_regfile
    import apex_seq_pkg::*;
#(
    parameter logic [15:0] CFG_BASE = 16'h0160
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        data_en_i,
    input  logic        data_wr_i,
    input  logic [15:0] data_addr_i,
    input  logic [15:0] data_wdata_i,
    input  logic        cfg_we_i,
    output logic [15:0] er_min_o,
    output logic [15:0] er_max_o,
    output logic [15:0] or_min_o,
    output logic [15:0] or_max_o,
    output logic        arm_p_o,
    output logic        clr_p_o,
    output logic        cfg_wr_p_o
);

    logic        cfg_hit;
    logic [15:0] ofs;
    logic [3:0]  ofs_w;
    logic        ctrl_hit;
    logic        unused_ofs;

    // Window decode; byte accesses fold onto their containing word.
    always_comb begin
        cfg_hit  = data_en_i && data_wr_i &&
                   (data_addr_i >= CFG_BASE) && (data_addr_i <= CFG_BASE + 16'd9);
        ofs      = data_addr_i - CFG_BASE;
        ofs_w    = {ofs[3:1], 1'b0};
        ctrl_hit = cfg_hit && (ofs_w == OFS_CTRL);
    end

    assign unused_ofs = ^{ofs[15:4], ofs[0]};

    assign cfg_wr_p_o = cfg_hit && !ctrl_hit;
    assign arm_p_o    = ctrl_hit && data_wdata_i[CTRL_ARM];
    assign clr_p_o    = ctrl_hit && data_wdata_i[CTRL_CLR];

    // Bound registers, written only while the FSM leaves the config unlocked.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            er_min_o <= 16'h0000;
            er_max_o <= 16'h0000;
            or_min_o <= 16'h0000;
            or_max_o <= 16'h0000;
        end else if (cfg_wr_p_o && cfg_we_i) begin
            case (ofs_w)
                OFS_ERMIN: er_min_o <= data_wdata_i;
                OFS_ERMAX: er_max_o <= data_wdata_i;
                OFS_ORMIN: or_min_o <= data_wdata_i;
                OFS_ORMAX: or_max_o <= data_wdata_i;
                default:   ;
            endcase
        end
    end

endmodule

// File: rtl/apex_exec_sequencer.sv
// Proof-of-execution sequencer: validates ER/OR bounds on ARM, locks config while
// armed, tracks entry at er_min and legal exit from er_max, reports DONE or FAULT.
// Optional run timeout enabled by defining APEX_SEQ_TIMEOUT_EN.
module apex_exec_sequencer
    import apex_seq_pkg::*;
#(
    parameter logic [15:0] CFG_BASE       = 16'h0160,
    parameter logic [15:0] TIMEOUT_CYCLES = 16'd1024
) (
    input  logic        clk,
    input  logic        puc_rst,
    input  logic [15:0] pc,
    input  logic        data_en,
    input  logic        data_wr,
    input  logic [15:0] data_addr,
    input  logic [15:0] data_wdata,
    input  logic        irq,
    output logic [15:0] er_min,
    output logic [15:0] er_max,
    output logic [15:0] or_min,
    output logic [15:0] or_max,
    output logic        cfg_locked,
    output logic        run_active,
    output logic        exec_done,
    output logic        fault,
    output logic [2:0]  fault_code
);

    state_e      state_q, state_d;
    logic [2:0]  code_q, code_d;
    logic [15:0] prev_pc_q, prev_pc_d;
    logic        arm_p, clr_p, cfg_wr_p;
    logic        cfg_ok;
    logic        pc_out;
    logic        timeout_hit;

    apex_cfg_regfile #(
        .CFG_BASE(CFG_BASE)
    ) u_cfg_regfile (
        .clk_i       (clk),
        .rst_i       (puc_rst),
        .data_en_i   (data_en),
        .data_wr_i   (data_wr),
        .data_addr_i (data_addr),
        .data_wdata_i(data_wdata),
        .cfg_we_i    (state_q == StIdle),
        .er_min_o    (er_min),
        .er_max_o    (er_max),
        .or_min_o    (or_min),
        .or_max_o    (or_max),
        .arm_p_o     (arm_p),
        .clr_p_o     (clr_p),
        .cfg_wr_p_o  (cfg_wr_p)
    );

    assign cfg_ok = (er_min <= er_max) && (or_min <= or_max) &&
                    !ranges_overlap(er_min, er_max, or_min, or_max);
    assign pc_out = (pc < er_min) || (pc > er_max);

`ifdef APEX_SEQ_TIMEOUT_EN
    logic [15:0] cnt_q, cnt_d;

    assign timeout_hit = (cnt_q == TIMEOUT_CYCLES - 16'd1);

    // Run-length counter; cleared on RUN entry, counts every RUN cycle.
    always_comb begin
        cnt_d = cnt_q;
        if (state_q == StArmed && pc == er_min) begin
            cnt_d = 16'd0;
        end else if (state_q == StRun) begin
            cnt_d = cnt_q + 16'd1;
        end
    end

    // Counter register.
    always_ff @(posedge clk or posedge puc_rst) begin
        if (puc_rst) begin
            cnt_q <= 16'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    logic unused_timeout;

    assign timeout_hit    = 1'b0;
    assign unused_timeout = ^TIMEOUT_CYCLES;
`endif

    // Next-state logic; CLR is applied last so it overrides every other event.
    always_comb begin
        state_d   = state_q;
        code_d    = code_q;
        prev_pc_d = prev_pc_q;
        unique case (state_q)
            StIdle: begin
                if (arm_p) begin
                    if (cfg_ok) begin
                        state_d = StArmed;
                    end else begin
                        state_d = StFault;
                        code_d  = FAULT_CFG_BAD;
                    end
                end
            end
            StArmed: begin
                if (pc == er_min) begin
                    state_d   = StRun;
                    prev_pc_d = pc;
                end
            end
            StRun: begin
                prev_pc_d = pc;
                if (irq) begin
                    state_d = StFault;
                    code_d  = FAULT_IRQ;
                end else if (cfg_wr_p) begin
                    state_d = StFault;
                    code_d  = FAULT_CFG_WRITE;
                end else if (timeout_hit) begin
                    state_d = StFault;
                    code_d  = FAULT_TIMEOUT;
                end else if (pc_out) begin
                    if (prev_pc_q == er_max) begin
                        state_d = StDone;
                    end else begin
                        state_d = StFault;
                        code_d  = FAULT_ILLEGAL_EXIT;
                    end
                end
            end
            StDone, StFault: ;
            default: begin
                state_d = StIdle;
                code_d  = FAULT_NONE;
            end
        endcase
        if (clr_p) begin
            state_d   = StIdle;
            code_d    = FAULT_NONE;
            prev_pc_d = 16'h0000;
        end
    end

    // State, fault code and previous-PC registers.
    always_ff @(posedge clk or posedge puc_rst) begin
        if (puc_rst) begin
            state_q   <= StIdle;
            code_q    <= FAULT_NONE;
            prev_pc_q <= 16'h0000;
        end else begin
            state_q   <= state_d;
            code_q    <= code_d;
            prev_pc_q <= prev_pc_d;
        end
    end

    assign cfg_locked = (state_q != StIdle);
    assign run_active = (state_q == StRun);
    assign exec_done  = (state_q == StDone);
    assign fault      = (state_q == StFault);
    assign fault_code = code_q;

endmodule

// File: tb/tb_apex_exec_sequencer.sv
// Self-checking bench for apex_exec_sequencer: expected status words are queued as
// each cycle's stimulus is driven and popped once the DUT has taken the edge.
module tb_apex_exec_sequencer;
    import apex_seq_pkg::*;

    localparam logic [15:0] Base          = 16'h0160;
    localparam logic [15:0] TimeoutCycles = 16'd200;

    logic        clk = 1'b0;
    logic        puc_rst = 1'b1;
    logic [15:0] pc = 16'h4400;
    logic        data_en = 1'b0;
    logic        data_wr = 1'b0;
    logic [15:0] data_addr = 16'h0000;
    logic [15:0] data_wdata = 16'h0000;
    logic        irq = 1'b0;
    logic [15:0] er_min, er_max, or_min, or_max;
    logic        cfg_locked, run_active, exec_done, fault;
    logic [2:0]  fault_code;

    int chk_cnt = 0;
    int err_cnt = 0;
    logic [6:0] exp_q[$];

    apex_exec_sequencer #(
        .CFG_BASE      (Base),
        .TIMEOUT_CYCLES(TimeoutCycles)
    ) u_dut (
        .clk       (clk),
        .puc_rst   (puc_rst),
        .pc        (pc),
        .data_en   (data_en),
        .data_wr   (data_wr),
        .data_addr (data_addr),
        .data_wdata(data_wdata),
        .irq       (irq),
        .er_min    (er_min),
        .er_max    (er_max),
        .or_min    (or_min),
        .or_max    (or_max),
        .cfg_locked(cfg_locked),
        .run_active(run_active),
        .exec_done (exec_done),
        .fault     (fault),
        .fault_code(fault_code)
    );

    always #5 clk = ~clk;

    wire [6:0] status = {cfg_locked, run_active, exec_done, fault, fault_code};

    function automatic logic [6:0] st(input state_e s, input logic [2:0] code);
        return {s != StIdle, s == StRun, s == StDone, s == StFault, code};
    endfunction

    task automatic check_eq(input string tag, input logic [15:0] act, input logic [15:0] exp);
        chk_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic step(input string tag, input logic [15:0] pc_v, input logic irq_v,
                        input logic wr_v, input logic [3:0] ofs, input logic [15:0] wd,
                        input logic [6:0] exp);
        pc         = pc_v;
        irq        = irq_v;
        data_en    = wr_v;
        data_wr    = wr_v;
        data_addr  = Base + {12'd0, ofs};
        data_wdata = wd;
        exp_q.push_back(exp);
        @(posedge clk);
        #1;
        data_en = 1'b0;
        data_wr = 1'b0;
        irq     = 1'b0;
        check_eq(tag, 16'(status), 16'(exp_q.pop_front()));
    endtask

    task automatic cyc(input string tag, input logic [15:0] pc_v, input logic [6:0] exp);
        step(tag, pc_v, 1'b0, 1'b0, 4'd0, 16'h0000, exp);
    endtask

    task automatic bus(input string tag, input logic [3:0] ofs, input logic [15:0] wd,
                       input logic [6:0] exp);
        step(tag, pc, 1'b0, 1'b1, ofs, wd, exp);
    endtask

    task automatic set_bounds(input logic [15:0] emin, input logic [15:0] emax,
                              input logic [15:0] omin, input logic [15:0] omax);
        bus("cfg_ermin", OFS_ERMIN, emin, st(StIdle, FAULT_NONE));
        bus("cfg_ermax", OFS_ERMAX, emax, st(StIdle, FAULT_NONE));
        bus("cfg_ormin", OFS_ORMIN, omin, st(StIdle, FAULT_NONE));
        bus("cfg_ormax", OFS_ORMAX, omax, st(StIdle, FAULT_NONE));
    endtask

    initial begin
        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_status", 16'(status), 16'h0000);
        check_eq("rst_ermin", er_min, 16'h0000);
        puc_rst = 1'b0;

        // 1: full legal run
        set_bounds(16'hE000, 16'hE0FE, 16'h0200, 16'h021E);
        check_eq("t1_ermin", er_min, 16'hE000);
        check_eq("t1_ermax", er_max, 16'hE0FE);
        check_eq("t1_ormin", or_min, 16'h0200);
        check_eq("t1_ormax", or_max, 16'h021E);
        bus("t1_arm", OFS_CTRL, 16'h0001, st(StArmed, FAULT_NONE));
        cyc("t1_idle_pc", 16'h4400, st(StArmed, FAULT_NONE));
        bus("t1_armed_wr", OFS_ERMIN, 16'h1234, st(StArmed, FAULT_NONE));
        check_eq("t1_armed_drop", er_min, 16'hE000);
        cyc("t1_entry", 16'hE000, st(StRun, FAULT_NONE));
        for (int a = 'hE002; a <= 'hE0FE; a += 2) begin
            cyc("t1_run", a[15:0], st(StRun, FAULT_NONE));
        end
        cyc("t1_exit", 16'h4400, st(StDone, FAULT_NONE));
        bus("t1_done_wr", OFS_ERMIN, 16'h1234, st(StDone, FAULT_NONE));
        check_eq("t1_done_drop", er_min, 16'hE000);
        bus("t1_clr", OFS_CTRL, 16'h0002, st(StIdle, FAULT_NONE));

        // 2: illegal exit, then CLR keeps bounds
        bus("t2_arm", OFS_CTRL, 16'h0001, st(StArmed, FAULT_NONE));
        cyc("t2_entry", 16'hE000, st(StRun, FAULT_NONE));
        for (int a = 'hE002; a <= 'hE010; a += 2) begin
            cyc("t2_run", a[15:0], st(StRun, FAULT_NONE));
        end
        cyc("t2_exit", 16'h4400, st(StFault, FAULT_ILLEGAL_EXIT));
        bus("t2_fault_wr", OFS_ERMAX, 16'h0000, st(StFault, FAULT_ILLEGAL_EXIT));
        cyc("t2_hold", 16'hE0FE, st(StFault, FAULT_ILLEGAL_EXIT));
        bus("t2_clr", OFS_CTRL, 16'h0002, st(StIdle, FAULT_NONE));
        check_eq("t2_keep_ermin", er_min, 16'hE000);
        check_eq("t2_keep_ermax", er_max, 16'hE0FE);

        // 3: invalid configurations
        set_bounds(16'hE100, 16'hE000, 16'h0200, 16'h021E);
        bus("t3_inverted", OFS_CTRL, 16'h0001, st(StFault, FAULT_CFG_BAD));
        bus("t3_clr1", OFS_CTRL, 16'h0002, st(StIdle, FAULT_NONE));
        set_bounds(16'hE000, 16'hE0FE, 16'hE080, 16'hE090);
        bus("t3_overlap", OFS_CTRL, 16'h0001, st(StFault, FAULT_CFG_BAD));
        bus("t3_clr2", OFS_CTRL, 16'h0002, st(StIdle, FAULT_NONE));
        set_bounds(16'hE000, 16'hE0FE, 16'h0200, 16'h021E);
        bus("t3_arm_clr", OFS_CTRL, 16'h0003, st(StIdle, FAULT_NONE));

        // 4: irq beats a same-cycle config write
        bus("t4_arm", OFS_CTRL, 16'h0001, st(StArmed, FAULT_NONE));
        cyc("t4_entry", 16'hE000, st(StRun, FAULT_NONE));
        step("t4_irq_wr", 16'hE002, 1'b1, 1'b1, OFS_ERMIN, 16'h1111, st(StFault, FAULT_IRQ));
        check_eq("t4_ermin", er_min, 16'hE000);
        bus("t4_clr", OFS_CTRL, 16'h0002, st(StIdle, FAULT_NONE));

        // config write during RUN
        bus("cw_arm", OFS_CTRL, 16'h0001, st(StArmed, FAULT_NONE));
        cyc("cw_entry", 16'hE000, st(StRun, FAULT_NONE));
        bus("cw_write", OFS_ERMAX, 16'h5555, st(StFault, FAULT_CFG_WRITE));
        check_eq("cw_ermax", er_max, 16'hE0FE);
        bus("cw_clr", OFS_CTRL, 16'h0002, st(StIdle, FAULT_NONE));

        // single-address ER at the top of memory
        set_bounds(16'hFFFF, 16'hFFFF, 16'h0200, 16'h021E);
        bus("one_arm", OFS_CTRL, 16'h0001, st(StArmed, FAULT_NONE));
        cyc("one_entry", 16'hFFFF, st(StRun, FAULT_NONE));
        cyc("one_exit", 16'h0000, st(StDone, FAULT_NONE));
        bus("one_clr", OFS_CTRL, 16'h0002, st(StIdle, FAULT_NONE));

        // 5: reset mid-run
        set_bounds(16'hE000, 16'hE0FE, 16'h0200, 16'h021E);
        bus("t5_arm", OFS_CTRL, 16'h0001, st(StArmed, FAULT_NONE));
        cyc("t5_entry", 16'hE000, st(StRun, FAULT_NONE));
        cyc("t5_run", 16'hE002, st(StRun, FAULT_NONE));
        #2;
        puc_rst = 1'b1;
        #1;
        check_eq("t5_status", 16'(status), 16'h0000);
        check_eq("t5_ermin", er_min, 16'h0000);
        check_eq("t5_ormax", or_max, 16'h0000);
        @(posedge clk);
        #1;
        puc_rst = 1'b0;

`ifdef APEX_SEQ_TIMEOUT_EN
        set_bounds(16'hE000, 16'hE0FE, 16'h0200, 16'h021E);
        bus("to_arm", OFS_CTRL, 16'h0001, st(StArmed, FAULT_NONE));
        cyc("to_entry", 16'hE000, st(StRun, FAULT_NONE));
        for (int i = 1; i < int'(TimeoutCycles); i++) begin
            cyc("to_run", 16'hE002, st(StRun, FAULT_NONE));
        end
        cyc("to_fault", 16'hE002, st(StFault, FAULT_TIMEOUT));
`endif

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
